mano_control_unit: RTL
======================

# mano_control_unit

Hardwired control sequencer for the Mano basic-computer datapath. It runs the fetch/decode/execute timing sequence (T0–T6), decodes the instruction register, and drives every register, bus, ALU and memory control of the datapath. It sits beside the datapath and closes the loop using IR, AC, DR and E as status inputs. Memory-reference and register-reference instructions are executed. I/O instructions complete as NOPs; interrupts are out of scope.

## Interface
Parameters:
- `SC_W`, default 3: sequence-counter width. T0..T6 must fit.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse; resumes execution from the halted state.
- `ir_in` in 16, `ac_in` in 16, `dr_in` in 16, `e_in` in 1: datapath status.
- `bus_select` out 3: bus source. 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM.
- `ar_load/ar_inc/ar_clr`, `pc_load/pc_inc/pc_clr`, `dr_load/dr_inc/dr_clr`, `ac_load/ac_inc/ac_clr`, `tr_load/tr_inc/tr_clr` out 1 each: register controls.
- `ir_load`, `outr_load` out 1: register loads. `outr_load` is never asserted.
- `e_load`, `e_clr`, `e_cmp` out 1: E load from ALU, clear, complement. The datapath E register gains clr and cmp inputs.
- `alu_opcode` out 3: 0 AND, 1 ADD, 2 PASS_DR, 3 CMA, 4 SHR (CIR), 5 SHL (CIL), 6 INPR, 7 PASS_AC.
- `mem_read`, `mem_write` out 1: memory strobes at address AR.
- `sc` out SC_W: current timing step, for debug.
- `halted` out 1: high after HLT.

## Operation
Every control output is a combinational function of `sc`, the decoded IR, the latched indirect bit I, the status inputs and `halted`. Any control not listed for a step is 0.

- **Reset** (`rst_n`=0): all *_clr outputs and `e_clr` are 1, all other outputs are 0. Next state: sc=T0, halted=0, I=0.
- **T0:** bus=PC, `ar_load`.
- **T1:** `mem_read`, bus=MEM, `ir_load`, `pc_inc`.
- **T2:** bus=IR, `ar_load` (AR takes bus[11:0]). Latch I from `ir_in[15]`.
- **T3, opcode 7, I=0 (register-reference):** execute, then SC←0.
  - CLA → `ac_clr`.
  - CLE → `e_clr`.
  - CMA → `ac_load`, op 3.
  - CME → `e_cmp`.
  - CIR → `ac_load` + `e_load`, op 4.
  - CIL → `ac_load` + `e_load`, op 5.
  - INC → `ac_inc`.
  - SPA/SNA/SZA/SZE → `pc_inc` if `ac_in[15]`=0 / `ac_in[15]`=1 / `ac_in`=0 / `e_in`=0.
  - HLT → halted←1.
  - Multiple bits set: skip conditions are ORed into a single `pc_inc`. Only one AC operation is performed, by priority CLA > CMA > CIR > CIL > INC. E operations follow priority CLE > CME > CIR/CIL.
- **T3, opcode 7, I=1 (I/O):** no-op, SC←0.
- **T3, opcode 0–6:** if I=1: `mem_read`, bus=MEM, `ar_load`. Otherwise idle. SC advances either way.
- **T4 onward, per opcode:**
  - AND: T4 DR←M; T5 `ac_load` op 0, SC←0.
  - ADD: T4 DR←M; T5 `ac_load` + `e_load` op 1, SC←0.
  - LDA: T4 DR←M; T5 `ac_load` op 2, SC←0.
  - STA: T4 bus=AC, `mem_write`, SC←0.
  - BUN: T4 bus=AR, `pc_load`, SC←0.
  - BSA: T4 bus=PC, `mem_write`, `ar_inc`; T5 bus=AR, `pc_load`, SC←0.
  - ISZ: T4 DR←M; T5 `dr_inc`; T6 bus=DR, `mem_write`, `pc_inc` if `dr_in`=0, SC←0.
  - "DR←M" means `mem_read`, bus=MEM, `dr_load`.
- **Halted:** all outputs 0 and sc held at T0. A `start` pulse clears `halted`; T0 is executed on the following cycle. `start` is ignored when not halted.

## Timing
- Instruction lengths in cycles:
  - register-reference and I/O: 4.
  - STA, BUN: 5 direct, 5 indirect (T3 is always spent).
  - AND/ADD/LDA/BSA: 6.
  - ISZ: 7.
- Status inputs are sampled in the same cycle they are used; the datapath updates registers on that edge.
- HLT: `halted` rises at the end of T3. Outputs are 0 from the next cycle.
- Reset mid-instruction: abandons the instruction at the next edge. No partial memory write is issued after reset is asserted.
- Only one bus source is active in any step, and `mem_read` and `mem_write` are never both 1.

## Structure
- Package `mano_pkg` holds:
  - bus-select constants;
  - ALU opcode constants;
  - memory-reference opcode constants (AND=0 … ISZ=6);
  - register-reference bit masks (CLA=0x800 … HLT=0x001);
  - T-state constants.
- Sub-module `instr_decoder`: combinational. Takes IR and produces the one-hot opcode D0–D7, the register-reference bit vector, and the I bit.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles → all clr outputs 1, sc=0. First cycle after release: bus_select=2, ar_load=1.
- LDA direct: M[000]=0x2005, M[005]=0x1234 → AC=0x1234 and PC=0x001 after 6 cycles; next fetch starts at sc=0.
- ADD indirect with carry: AC=0xFFFF, M[000]=0x9010, M[010]=0x0020, M[020]=0x0002 → AC=0x0001, E=1.
- ISZ wrap: M[000]=0x6030, M[030]=0xFFFF → M[030]=0x0000 and PC=0x002 after 7 cycles.
- BSA then SZA: M[000]=0x5040 → M[040]=0x001, PC=0x041. At 0x041, SZA (0x7004) with AC=0 → PC=0x043.
- HLT/start: M[000]=0x7001 → halted=1 after 4 cycles, outputs stay 0 for 10 cycles. A `start` pulse → fetch at PC=0x001.

Source files
------------

// File: rtl/mano_pkg.sv
// rtl/mano_pkg.sv - shared constants for the Mano basic-computer control sequencer
package mano_pkg;

   localparam logic [2:0] BUS_NONE = 3'd0;
   localparam logic [2:0] BUS_AR   = 3'd1;
   localparam logic [2:0] BUS_PC   = 3'd2;
   localparam logic [2:0] BUS_DR   = 3'd3;
   localparam logic [2:0] BUS_AC   = 3'd4;
   localparam logic [2:0] BUS_IR   = 3'd5;
   localparam logic [2:0] BUS_TR   = 3'd6;
   localparam logic [2:0] BUS_MEM  = 3'd7;

   localparam logic [2:0] ALU_AND     = 3'd0;
   localparam logic [2:0] ALU_ADD     = 3'd1;
   localparam logic [2:0] ALU_PASS_DR = 3'd2;
   localparam logic [2:0] ALU_CMA     = 3'd3;
   localparam logic [2:0] ALU_SHR     = 3'd4;
   localparam logic [2:0] ALU_SHL     = 3'd5;
   localparam logic [2:0] ALU_INPR    = 3'd6;
   localparam logic [2:0] ALU_PASS_AC = 3'd7;

   localparam int OP_AND = 0;
   localparam int OP_ADD = 1;
   localparam int OP_LDA = 2;
   localparam int OP_STA = 3;
   localparam int OP_BUN = 4;
   localparam int OP_BSA = 5;
   localparam int OP_ISZ = 6;
   localparam int OP_RIO = 7;

   localparam logic [11:0] RR_CLA = 12'h800;
   localparam logic [11:0] RR_CLE = 12'h400;
   localparam logic [11:0] RR_CMA = 12'h200;
   localparam logic [11:0] RR_CME = 12'h100;
   localparam logic [11:0] RR_CIR = 12'h080;
   localparam logic [11:0] RR_CIL = 12'h040;
   localparam logic [11:0] RR_INC = 12'h020;
   localparam logic [11:0] RR_SPA = 12'h010;
   localparam logic [11:0] RR_SNA = 12'h008;
   localparam logic [11:0] RR_SZA = 12'h004;
   localparam logic [11:0] RR_SZE = 12'h002;
   localparam logic [11:0] RR_HLT = 12'h001;

   localparam int T0 = 0;
   localparam int T1 = 1;
   localparam int T2 = 2;
   localparam int T3 = 3;
   localparam int T4 = 4;
   localparam int T5 = 5;
   localparam int T6 = 6;

   function automatic logic rr_has(input logic [11:0] rr, input logic [11:0] mask);
      return |(rr & mask);
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - splits IR into one-hot opcode, register-reference bits and I bit
module instr_decoder
   import mano_pkg::*;
(
   input  logic [15:0] i_ir,
   output logic [7:0]  o_d,
   output logic [11:0] o_rr,
   output logic        o_i
);

   assign o_d  = 8'd1 << i_ir[14:12];
   assign o_rr = i_ir[11:0];
   assign o_i  = i_ir[15];

endmodule

// File: rtl/mano_control_unit.sv
// rtl/mano_control_unit.sv - hardwired T0..T6 sequencer driving the Mano datapath controls
module mano_control_unit
   import mano_pkg::*;
#(
   parameter int SC_W = 3
)(
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic [15:0]     i_ir,
   input  logic [15:0]     i_ac,
   input  logic [15:0]     i_dr,
   input  logic            i_e,
   output logic [2:0]      o_bus_select,
   output logic            o_ar_load,
   output logic            o_ar_inc,
   output logic            o_ar_clr,
   output logic            o_pc_load,
   output logic            o_pc_inc,
   output logic            o_pc_clr,
   output logic            o_dr_load,
   output logic            o_dr_inc,
   output logic            o_dr_clr,
   output logic            o_ac_load,
   output logic            o_ac_inc,
   output logic            o_ac_clr,
   output logic            o_tr_load,
   output logic            o_tr_inc,
   output logic            o_tr_clr,
   output logic            o_ir_load,
   output logic            o_outr_load,
   output logic            o_e_load,
   output logic            o_e_clr,
   output logic            o_e_cmp,
   output logic [2:0]      o_alu_opcode,
   output logic            o_mem_read,
   output logic            o_mem_write,
   output logic [SC_W-1:0] o_sc,
   output logic            o_halted
);

   logic [SC_W-1:0] r_sc;
   logic            r_halted;
   logic            r_i;
   logic [7:0]      w_d;
   logic [11:0]     w_rr;
   logic            w_i;
   logic            w_skip;
   logic            w_shift;

   instr_decoder u_dec (
      .i_ir (i_ir),
      .o_d  (w_d),
      .o_rr (w_rr),
      .o_i  (w_i)
   );

   assign w_skip = (rr_has(w_rr, RR_SPA) & ~i_ac[15]) | (rr_has(w_rr, RR_SNA) & i_ac[15]) |
                   (rr_has(w_rr, RR_SZA) & (i_ac == 16'h0000)) | (rr_has(w_rr, RR_SZE) & ~i_e);
   // E only follows a rotate when that rotate is the AC operation actually performed
   assign w_shift = ~rr_has(w_rr, RR_CLA) & ~rr_has(w_rr, RR_CMA) & rr_has(w_rr, RR_CIR | RR_CIL);

   assign o_sc     = i_rst_n ? r_sc : '0;
   assign o_halted = i_rst_n & r_halted;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sc     <= '0;
         r_halted <= 1'b0;
         r_i      <= 1'b0;
      end else if (r_halted) begin
         r_sc <= '0;
         if (i_start) r_halted <= 1'b0;
      end else begin
         case (int'(r_sc))
            T0, T1: r_sc <= r_sc + SC_W'(1);
            T2: begin
               r_i  <= w_i;
               r_sc <= SC_W'(T3);
            end
            T3: begin
               if (w_d[OP_RIO]) begin
                  r_sc <= '0;
                  if (!r_i && rr_has(w_rr, RR_HLT)) r_halted <= 1'b1;
               end else begin
                  r_sc <= SC_W'(T4);
               end
            end
            T4: r_sc <= (w_d[OP_STA] | w_d[OP_BUN]) ? '0 : SC_W'(T5);
            T5: r_sc <= w_d[OP_ISZ] ? SC_W'(T6) : '0;
            default: r_sc <= '0;
         endcase
      end
   end

   always_comb begin
      o_bus_select = BUS_NONE;
      o_ar_load    = 1'b0;
      o_ar_inc     = 1'b0;
      o_ar_clr     = 1'b0;
      o_pc_load    = 1'b0;
      o_pc_inc     = 1'b0;
      o_pc_clr     = 1'b0;
      o_dr_load    = 1'b0;
      o_dr_inc     = 1'b0;
      o_dr_clr     = 1'b0;
      o_ac_load    = 1'b0;
      o_ac_inc     = 1'b0;
      o_ac_clr     = 1'b0;
      o_tr_load    = 1'b0;
      o_tr_inc     = 1'b0;
      o_tr_clr     = 1'b0;
      o_ir_load    = 1'b0;
      o_outr_load  = 1'b0;
      o_e_load     = 1'b0;
      o_e_clr      = 1'b0;
      o_e_cmp      = 1'b0;
      o_alu_opcode = ALU_AND;
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      if (!i_rst_n) begin
         o_ar_clr = 1'b1;
         o_pc_clr = 1'b1;
         o_dr_clr = 1'b1;
         o_ac_clr = 1'b1;
         o_tr_clr = 1'b1;
         o_e_clr  = 1'b1;
      end else if (!r_halted) begin
         case (int'(r_sc))
            T0: begin
               o_bus_select = BUS_PC;
               o_ar_load    = 1'b1;
            end
            T1: begin
               o_mem_read   = 1'b1;
               o_bus_select = BUS_MEM;
               o_ir_load    = 1'b1;
               o_pc_inc     = 1'b1;
            end
            T2: begin
               o_bus_select = BUS_IR;
               o_ar_load    = 1'b1;
            end
            T3: begin
               if (w_d[OP_RIO]) begin
                  if (!r_i) begin
                     if (rr_has(w_rr, RR_CLA)) o_ac_clr = 1'b1;
                     else if (rr_has(w_rr, RR_CMA)) begin
                        o_ac_load    = 1'b1;
                        o_alu_opcode = ALU_CMA;
                     end else if (rr_has(w_rr, RR_CIR)) begin
                        o_ac_load    = 1'b1;
                        o_alu_opcode = ALU_SHR;
                     end else if (rr_has(w_rr, RR_CIL)) begin
                        o_ac_load    = 1'b1;
                        o_alu_opcode = ALU_SHL;
                     end else if (rr_has(w_rr, RR_INC)) o_ac_inc = 1'b1;
                     if (rr_has(w_rr, RR_CLE)) o_e_clr = 1'b1;
                     else if (rr_has(w_rr, RR_CME)) o_e_cmp = 1'b1;
                     else if (w_shift) o_e_load = 1'b1;
                     o_pc_inc = w_skip;
                  end
               end else if (r_i) begin
                  o_mem_read   = 1'b1;
                  o_bus_select = BUS_MEM;
                  o_ar_load    = 1'b1;
               end
            end
            T4: begin
               if (w_d[OP_AND] | w_d[OP_ADD] | w_d[OP_LDA] | w_d[OP_ISZ]) begin
                  o_mem_read   = 1'b1;
                  o_bus_select = BUS_MEM;
                  o_dr_load    = 1'b1;
               end else if (w_d[OP_STA]) begin
                  o_bus_select = BUS_AC;
                  o_mem_write  = 1'b1;
               end else if (w_d[OP_BUN]) begin
                  o_bus_select = BUS_AR;
                  o_pc_load    = 1'b1;
               end else if (w_d[OP_BSA]) begin
                  o_bus_select = BUS_PC;
                  o_mem_write  = 1'b1;
                  o_ar_inc     = 1'b1;
               end
            end
            T5: begin
               if (w_d[OP_AND]) begin
                  o_ac_load    = 1'b1;
                  o_alu_opcode = ALU_AND;
               end else if (w_d[OP_ADD]) begin
                  o_ac_load    = 1'b1;
                  o_e_load     = 1'b1;
                  o_alu_opcode = ALU_ADD;
               end else if (w_d[OP_LDA]) begin
                  o_ac_load    = 1'b1;
                  o_alu_opcode = ALU_PASS_DR;
               end else if (w_d[OP_BSA]) begin
                  o_bus_select = BUS_AR;
                  o_pc_load    = 1'b1;
               end else if (w_d[OP_ISZ]) o_dr_inc = 1'b1;
            end
            T6: begin
               if (w_d[OP_ISZ]) begin
                  o_bus_select = BUS_DR;
                  o_mem_write  = 1'b1;
                  o_pc_inc     = (i_dr == 16'h0000);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
